param_regfile_sb: RTL and testbench
===================================

Name: param_regfile_sb

Overview:
- Parametrised successor of the CPU base register file: DEPTH x DATA_W storage, two asynchronous read ports and one synchronous write port.
- Adds a per-register scoreboard (busy bits) so the pipeline can detect pending writes on source operands.
- Adds a hardware clear sweep, started by reset or a `clr` request, that zeroes every register one entry per cycle.
- Sits between the decode/issue stage (reads, reserve) and writeback (write, release).

Parameters:
- DATA_W, 32, width of each register
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 hardwired to zero, never written, never busy; 0 = entry 0 is an ordinary register

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- clr  in  1  request clear sweep; sampled only in state RUN
- ready  out  1  1 = normal operation; 0 = sweep in progress
- WE  in  1  write enable
- rW  in  ADDR_W  write address
- W  in  DATA_W  write data
- rA  in  ADDR_W  read address, port A
- rB  in  ADDR_W  read address, port B
- A  out  DATA_W  read data, port A
- B  out  DATA_W  read data, port B
- rsv_en  in  1  reserve `rsv_addr` as pending
- rsv_addr  in  ADDR_W  register to mark busy
- a_busy  out  1  entry rA has a pending write
- b_busy  out  1  entry rB has a pending write

Behaviour:
- One clock, `clk`. Reset `rst_n` is synchronous and active-low: sampled on the rising edge of `clk`; when 0, state goes to SWEEP and sweep counter goes to 0.
- Reset outputs: ready=0; A=B=0; a_busy=b_busy=0. Storage contents are zeroed by the sweep, not by reset itself.
- States: SWEEP, RUN.
- SWEEP:
  - Each cycle, write 0 to entry `cnt` and clear busy[cnt]; then cnt++.
  - When cnt == DEPTH-1, that entry is cleared and the next state is RUN.
  - Sweep length is exactly DEPTH cycles; ready=1 on cycle DEPTH after the sweep starts.
  - WE and rsv_en are ignored. A, B, a_busy and b_busy are forced to 0.
- RUN:
  - clr=1 enters SWEEP next cycle with cnt=0.
  - A WE or rsv_en in the same cycle as clr is still performed; the sweep overwrites it later.
- rst_n=0 mid-sweep restarts the sweep from cnt=0.
- Read ports are combinational:
  - A = mem[rA], B = mem[rB].
  - With ZERO_REG=1, address 0 always reads 0.
- Write: on the rising edge, if WE and state RUN and !(ZERO_REG && rW==0), then mem[rW] <= W.
- Scoreboard, evaluated on the rising edge in RUN:
  - WE to rW clears busy[rW].
  - rsv_en sets busy[rsv_addr], except address 0 when ZERO_REG=1.
  - rsv_en and WE to the same address in the same cycle: reserve wins, busy stays 1 (new producer).
  - Reserving an entry that is already busy keeps it busy; no error.
- Busy outputs: a_busy = busy[rA], b_busy = busy[rB]; forced 0 in SWEEP (see bypass override).
- rA == rB is legal; both ports return identical data and busy.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding in RUN.
  - If WE and rW == rA (and rW is not the zero register), then A = W in the same cycle and a_busy = 0.
  - Same rule for port B.
- Not defined:
  - Reads return the stored value; a same-cycle write is visible only from the next cycle.
  - a_busy / b_busy reflect stored busy bits only.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release. Required: ready=0 for exactly 32 cycles, then 1; A=B=0 for all rA/rB 0..31.
- Write/read: WE=1, rW=5, W=0xDEADBEEF. Required: next cycle, rA=5 gives A=0xDEADBEEF. Write rW=0, W=0x1234. Required: A=0 at rA=0 (ZERO_REG=1).
- Scoreboard:
  - rsv_en, rsv_addr=7. Required: next cycle, rA=7 gives a_busy=1.
  - WE rW=7. Required: next cycle a_busy=0.
  - Simultaneous rsv_en(7) and WE(7). Required: busy stays 1, mem[7]=W.
- Clear mid-run: fill regs 1..31 with 0xA5A5A5A5, reserve reg 3, pulse clr with a WE to reg 9 in that cycle. Required: ready=0 for 32 cycles; afterwards all reads 0 and b_busy=0 at rB=3.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 10. Required: ready stays 0 for a full 32 cycles after release.
- Bypass (REGFILE_BYPASS_EN): reg 4 busy; WE rW=4, W=0x55 with rA=4 in the same cycle. Required: A=0x55 and a_busy=0 that cycle. Without the macro: A = old value, a_busy=1 that cycle.

Source files
------------

// File: rtl/param_regfile_sb.sv
// param_regfile_sb: DEPTH x DATA_W register file with two combinational read
// ports, one synchronous write port, per-entry busy scoreboard and a hardware
// clear sweep (one entry per cycle) started by reset or clr.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module param_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              ready,
    input  logic              WE,
    input  logic [ADDR_W-1:0] rW,
    input  logic [DATA_W-1:0] W,
    input  logic [ADDR_W-1:0] rA,
    input  logic [ADDR_W-1:0] rB,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              a_busy,
    output logic              b_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {SWEEP, RUN} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic run, do_wr, do_rsv, w_zero, rsv_zero, a_zero, b_zero;

    assign run      = (state == RUN);
    assign w_zero   = (ZERO_REG != 0) && (rW == '0);
    assign rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);
    assign a_zero   = (ZERO_REG != 0) && (rA == '0);
    assign b_zero   = (ZERO_REG != 0) && (rB == '0);
    // Writes and reservations only take effect while running; the zero
    // register silently absorbs both.
    assign do_wr    = run && WE && !w_zero;
    assign do_rsv   = run && rsv_en && !rsv_zero;
    assign ready    = run;

    // State register and sweep counter; counter rests at 0 while running so a
    // clr-initiated sweep starts at entry 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SWEEP;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == SWEEP) ? cnt + 1'b1 : '0;
        end
    end

    // Next state: sweep ends after the last entry, clr restarts it from RUN.
    always_comb begin
        state_nx = state;
        case (state)
            SWEEP: if (cnt == ADDR_W'(DEPTH - 1)) state_nx = RUN;
            RUN:   if (clr) state_nx = SWEEP;
            default: state_nx = SWEEP;
        endcase
    end

    // Storage: sweep zeroes entry cnt, otherwise the write port updates rW.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == SWEEP)
                mem[cnt] <= '0;
            else if (do_wr)
                mem[rW] <= W;
        end
    end

    // Scoreboard: writeback releases, reserve sets; reserve is applied last so
    // a same-address reserve+write leaves the entry busy for the new producer.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == SWEEP) begin
                busy[cnt] <= 1'b0;
            end else begin
                if (do_wr)  busy[rW]       <= 1'b0;
                if (do_rsv) busy[rsv_addr] <= 1'b1;
            end
        end
    end

    // Read port A: stored value/busy, optional forwarding, forced 0 in sweep.
    always_comb begin
        A      = a_zero ? '0 : mem[rA];
        a_busy = busy[rA];
`ifdef REGFILE_BYPASS_EN
        if (do_wr && (rW == rA)) begin
            A      = W;
            a_busy = 1'b0;
        end
`endif
        if (!run) begin
            A      = '0;
            a_busy = 1'b0;
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        B      = b_zero ? '0 : mem[rB];
        b_busy = busy[rB];
`ifdef REGFILE_BYPASS_EN
        if (do_wr && (rW == rB)) begin
            B      = W;
            b_busy = 1'b0;
        end
`endif
        if (!run) begin
            B      = '0;
            b_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_param_regfile_sb.sv
// Self-checking bench for param_regfile_sb (DATA_W=32, ADDR_W=5, ZERO_REG=1).
// Expected read results are queued when stimulus is driven and popped when the
// DUT output becomes valid.
module tb_param_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n, clr, ready, WE, rsv_en, a_busy, b_busy;
    logic [4:0]  rW, rA, rB, rsv_addr;
    logic [31:0] W, A, B;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    param_regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready),
        .WE(WE), .rW(rW), .W(W), .rA(rA), .rB(rB), .A(A), .B(B),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .a_busy(a_busy), .b_busy(b_busy)
    );

    always #5 clk = ~clk;

    // advance one cycle; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // count cycles until ready rises, bounded
    task automatic count_sweep(output int n);
        n = 0;
        while (!ready && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; clr = 0; WE = 0; rsv_en = 0;
        rW = 0; W = 0; rA = 0; rB = 0; rsv_addr = 0;
        tick(); tick();
        checks++;
        if (ready !== 1'b0 || A !== 32'd0 || B !== 32'd0 || a_busy !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b A=%h B=%h ab=%b bb=%b, want 0", ready, A, B, a_busy, b_busy);
        end
        rst_n = 1'b1;
        count_sweep(n);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL reset_sweep_len: got %0d cycles, want 32", n);
        end
        for (int i = 0; i < 32; i++) exp_q.push_back('{addr: 5'(i), data: 32'd0, busy: 1'b0});
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            rA = e.addr; rB = 5'(31 - int'(e.addr));
            #1;
            checks++;
            if (A !== e.data || B !== e.data) begin
                errors++;
                $display("FAIL reset_read[%0d]: A=%h B=%h, want %h", e.addr, A, B, e.data);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        WE = 1; rW = 5; W = 32'hDEADBEEF; rA = 5;
        exp_q.push_back('{addr: 5, data: 32'hDEADBEEF, busy: 1'b0});
        tick();
        WE = 1; rW = 0; W = 32'h1234;
        exp_q.push_back('{addr: 0, data: 32'h0, busy: 1'b0});
        e = exp_q.pop_front();
        rA = e.addr; rB = e.addr;
        #1;
        checks++;
        if (A !== e.data || B !== e.data) begin
            errors++;
            $display("FAIL write_read_5: A=%h B=%h, want %h", A, B, e.data);
        end
        tick();
        WE = 0;
        e = exp_q.pop_front();
        rA = e.addr;
        #1;
        checks++;
        if (A !== e.data) begin
            errors++;
            $display("FAIL write_zero_reg: A=%h, want %h", A, e.data);
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        rsv_en = 1; rsv_addr = 7;
        exp_q.push_back('{addr: 7, data: 32'h0, busy: 1'b1});
        tick();
        rsv_en = 0;
        e = exp_q.pop_front();
        rA = e.addr; rB = e.addr;
        #1;
        checks++;
        if (a_busy !== e.busy || b_busy !== e.busy) begin
            errors++;
            $display("FAIL sb_reserve: a_busy=%b b_busy=%b, want %b", a_busy, b_busy, e.busy);
        end
        WE = 1; rW = 7; W = 32'h77;
        exp_q.push_back('{addr: 7, data: 32'h77, busy: 1'b0});
        tick();
        WE = 0;
        e = exp_q.pop_front();
        #1;
        checks++;
        if (a_busy !== e.busy || A !== e.data) begin
            errors++;
            $display("FAIL sb_release: a_busy=%b A=%h, want %b %h", a_busy, A, e.busy, e.data);
        end
        WE = 1; rW = 7; W = 32'h99; rsv_en = 1; rsv_addr = 7;
        exp_q.push_back('{addr: 7, data: 32'h99, busy: 1'b1});
        tick();
        WE = 0; rsv_en = 0;
        e = exp_q.pop_front();
        #1;
        checks++;
        if (a_busy !== e.busy || A !== e.data) begin
            errors++;
            $display("FAIL sb_rsv_wins: a_busy=%b A=%h, want %b %h", a_busy, A, e.busy, e.data);
        end
        // release again so later tests start clean
        WE = 1; rW = 7; W = 32'h0;
        tick();
        WE = 0;
    endtask

    task automatic test_clear_mid_run();
        int n;
        for (int i = 1; i < 32; i++) begin
            WE = 1; rW = 5'(i); W = 32'hA5A5A5A5;
            tick();
        end
        WE = 0;
        rsv_en = 1; rsv_addr = 3;
        tick();
        rsv_en = 0;
        rA = 17; rB = 3;
        #1;
        checks++;
        if (A !== 32'hA5A5A5A5 || b_busy !== 1'b1) begin
            errors++;
            $display("FAIL clr_prefill: A=%h b_busy=%b, want a5a5a5a5 1", A, b_busy);
        end
        clr = 1; WE = 1; rW = 9; W = 32'h1111;
        tick();
        clr = 0; WE = 0;
        count_sweep(n);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL clr_sweep_len: got %0d cycles, want 32", n);
        end
        for (int i = 0; i < 32; i++) exp_q.push_back('{addr: 5'(i), data: 32'd0, busy: 1'b0});
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            rA = e.addr; rB = e.addr;
            #1;
            checks++;
            if (A !== e.data || B !== e.data || a_busy !== e.busy || b_busy !== e.busy) begin
                errors++;
                $display("FAIL clr_read[%0d]: A=%h B=%h ab=%b bb=%b, want %h %b", e.addr, A, B, a_busy, b_busy, e.data, e.busy);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        count_sweep(n);
        checks++;
        if (n !== 32) begin
            errors++;
            $display("FAIL reset_mid_sweep_len: got %0d cycles, want 32", n);
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        WE = 1; rW = 4; W = 32'h44;
        tick();
        WE = 0; rsv_en = 1; rsv_addr = 4;
        tick();
        rsv_en = 0;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back('{addr: 4, data: 32'h55, busy: 1'b0});
`else
        exp_q.push_back('{addr: 4, data: 32'h44, busy: 1'b1});
`endif
        exp_q.push_back('{addr: 4, data: 32'h55, busy: 1'b0});
        WE = 1; rW = 4; W = 32'h55; rA = 4; rB = 4;
        e = exp_q.pop_front();
        #1;
        checks++;
        if (A !== e.data || a_busy !== e.busy || B !== e.data || b_busy !== e.busy) begin
            errors++;
            $display("FAIL bypass_same_cycle: A=%h ab=%b B=%h bb=%b, want %h %b", A, a_busy, B, b_busy, e.data, e.busy);
        end
        tick();
        WE = 0;
        e = exp_q.pop_front();
        #1;
        checks++;
        if (A !== e.data || a_busy !== e.busy) begin
            errors++;
            $display("FAIL bypass_next_cycle: A=%h ab=%b, want %h %b", A, a_busy, e.data, e.busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_clear_mid_run();
        test_reset_mid_sweep();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
